// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 LSB-first UART transmitter with a small byte FIFO in front.
// A valid/ready producer fills the FIFO; the transmit FSM pops one byte per
// frame and holds every bit for divisor_i+1 clock cycles. The divisor is
// latched at pop time, so changing it mid-frame only affects the next frame.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 32
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [DIV_W-1:0]              divisor_i,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Reset synchroniser
    logic [1:0]       r_rst_sync;
    logic             w_rstn;

    // FIFO storage and bookkeeping
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;

    // Transmit engine
    state_t           r_state;
    logic [7:0]       r_shift;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic             r_tx;

    logic             w_push;
    logic             w_pop;
    logic             w_cnt_zero;
    logic             w_not_empty;

    // Reset asserts asynchronously and is released two edges after rstn_i rises
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rstn      = r_rst_sync[1];

    assign w_not_empty = (r_level != {LW{1'b0}});
    assign w_cnt_zero  = (r_cnt == {DIV_W{1'b0}});
    assign ready_o     = (r_level != LVL_FULL);
    assign w_push      = valid_i && ready_o;
    // A frame starts from IDLE, or directly out of the final STOP cycle so
    // queued bytes go out back to back without an idle gap.
    assign w_pop       = w_not_empty &&
                         ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_cnt_zero));

    assign tx_o        = r_tx;
    assign level_o     = r_level;
    assign busy_o      = (r_state != ST_IDLE) || w_not_empty;

    // FIFO write/read pointers, storage and occupancy; pointers wrap naturally
    always_ff @(posedge clk_i or negedge w_rstn) begin
        if (!w_rstn) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_level  <= {LW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= data_i;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Transmit FSM: per-bit down-counter, bit index, shift register and serial output
    always_ff @(posedge clk_i or negedge w_rstn) begin
        if (!w_rstn) begin
            r_state <= ST_IDLE;
            r_shift <= 8'h00;
            r_div   <= {DIV_W{1'b0}};
            r_cnt   <= {DIV_W{1'b0}};
            r_bit   <= 3'd0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_div   <= divisor_i;
                        r_cnt   <= divisor_i;
                        r_bit   <= 3'd0;
                        r_tx    <= 1'b0;
                        r_state <= ST_START;
                    end else begin
                        r_tx    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_cnt_zero) begin
                        r_cnt   <= r_div;
                        r_tx    <= r_shift[0];
                        r_bit   <= 3'd0;
                        r_state <= ST_DATA;
                    end else begin
                        r_cnt   <= r_cnt - DIV_W'(1);
                    end
                end
                ST_DATA: begin
                    if (w_cnt_zero) begin
                        r_cnt <= r_div;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end
                end
                ST_STOP: begin
                    if (w_cnt_zero) begin
                        if (w_pop) begin
                            r_shift <= r_mem[r_rd_ptr];
                            r_div   <= divisor_i;
                            r_cnt   <= divisor_i;
                            r_bit   <= 3'd0;
                            r_tx    <= 1'b0;
                            r_state <= ST_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
